// File: rtl/symbol_round_sequencer.sv
// Symbol round sequencer: feeds LFSR-chosen indices to the registered symbol lookup,
// times each symbol's dwell and blank intervals, counts target hits and judges the guess.
module symbol_round_sequencer #(
    parameter int unsigned NUM_SYMS = 16,
    parameter int unsigned CNT_W    = 5,
    parameter int unsigned DWELL    = 50000000,
    parameter int unsigned GAP      = 12500000,
    parameter int unsigned TMR_W    = 26,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic             ClkSymGen,
    input  logic             nRst,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       targetIdx,
    input  logic             guessValid,
    input  logic [CNT_W-1:0] guess,
    output logic [3:0]       randomNum,
    output logic             symValid,
    output logic             busy,
    output logic             done,
    output logic             correct,
    output logic [CNT_W-1:0] targetCount
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHOW   = 3'd2,
        ST_GAP    = 3'd3,
        ST_ANSWER = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    localparam logic [TMR_W-1:0] TMR_DWELL    = TMR_W'(DWELL);
    localparam logic [TMR_W-1:0] TMR_GAP_LAST = TMR_W'(GAP - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO     = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(NUM_SYMS);

    // Count register must never wrap, and both intervals must fit the timer.
    if ((NUM_SYMS < 1) || (64'(NUM_SYMS) >= (64'd1 << CNT_W)) ||
        (DWELL < 1) || (GAP < 1) || (64'(DWELL) >= (64'd1 << TMR_W)) ||
        (64'(GAP) > (64'd1 << TMR_W)) || (SEED == 16'h0000)) begin : g_param_check
        $error("symbol_round_sequencer: illegal parameter combination");
    end

    // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nxt_s;
    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_nxt_s;
    logic [CNT_W-1:0] sym_idx_r;
    logic [CNT_W-1:0] sym_idx_nxt_s;
    logic [3:0]       target_r;
    logic [3:0]       target_nxt_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [3:0]       rnum_r;
    logic [3:0]       rnum_nxt_s;
    logic             sym_valid_r;
    logic             sym_valid_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    logic             done_r;
    logic             done_nxt_s;
    logic             correct_r;
    logic             correct_nxt_s;

    // Next-state and next-datapath decode; abort overrides every state, start included.
    always_comb begin
        state_nxt_s   = state_r;
        lfsr_nxt_s    = lfsr_r;
        timer_nxt_s   = timer_r;
        sym_idx_nxt_s = sym_idx_r;
        target_nxt_s  = target_r;
        count_nxt_s   = count_r;
        rnum_nxt_s    = rnum_r;
        correct_nxt_s = correct_r;
        if (abort) begin
            state_nxt_s   = ST_IDLE;
            correct_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s   = ST_LOAD;
                        target_nxt_s  = targetIdx;
                        count_nxt_s   = CNT_ZERO;
                        sym_idx_nxt_s = CNT_ZERO;
                        correct_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    rnum_nxt_s  = lfsr_r[3:0];
                    lfsr_nxt_s  = lfsr_step(lfsr_r);
                    timer_nxt_s = TMR_DWELL;
                    state_nxt_s = ST_SHOW;
                    if (lfsr_r[3:0] == target_r) begin
                        count_nxt_s = count_r + CNT_ONE;
                    end else begin
                        count_nxt_s = count_r;
                    end
                end
                ST_SHOW: begin
                    if (timer_r == TMR_ZERO) begin
                        state_nxt_s   = ST_GAP;
                        timer_nxt_s   = TMR_GAP_LAST;
                        sym_idx_nxt_s = sym_idx_r + CNT_ONE;
                    end else begin
                        timer_nxt_s = timer_r - TMR_ONE;
                    end
                end
                ST_GAP: begin
                    if (timer_r != TMR_ZERO) begin
                        timer_nxt_s = timer_r - TMR_ONE;
                    end else if (sym_idx_r == CNT_LAST) begin
                        state_nxt_s = ST_ANSWER;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_ANSWER: begin
                    if (guessValid) begin
                        correct_nxt_s = (guess == count_r);
                        state_nxt_s   = ST_RESULT;
                    end else begin
                        state_nxt_s = ST_ANSWER;
                    end
                end
                ST_RESULT: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        // First SHOW cycle stays blank to cover the lookup's one-cycle latency.
        sym_valid_nxt_s = (!abort) && (state_r == ST_SHOW) && (timer_r != TMR_ZERO);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        done_nxt_s      = (state_nxt_s == ST_RESULT);
    end

    // State register.
    always_ff @(posedge ClkSymGen or negedge nRst) begin
        if (!nRst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge ClkSymGen or negedge nRst) begin
        if (!nRst) begin
            lfsr_r      <= SEED;
            timer_r     <= TMR_ZERO;
            sym_idx_r   <= CNT_ZERO;
            target_r    <= 4'h0;
            count_r     <= CNT_ZERO;
            rnum_r      <= 4'h0;
            sym_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            correct_r   <= 1'b0;
        end else begin
            lfsr_r      <= lfsr_nxt_s;
            timer_r     <= timer_nxt_s;
            sym_idx_r   <= sym_idx_nxt_s;
            target_r    <= target_nxt_s;
            count_r     <= count_nxt_s;
            rnum_r      <= rnum_nxt_s;
            sym_valid_r <= sym_valid_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            correct_r   <= correct_nxt_s;
        end
    end

    assign randomNum   = rnum_r;
    assign symValid    = sym_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign correct     = correct_r;
    assign targetCount = count_r;

endmodule

// File: tb/tb_symbol_round_sequencer.sv
// Self-checking bench for symbol_round_sequencer: random targets and guesses checked
// against a symbol-list / cycle-offset reference model of a round.
module tb_symbol_round_sequencer;

    localparam int NUM_SYMS = 4;
    localparam int CNT_W    = 3;
    localparam int DWELL    = 3;
    localparam int GAP      = 2;
    localparam int TMR_W    = 4;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int PER      = DWELL + GAP + 2;
    localparam int ANS_K    = NUM_SYMS * PER;

    logic             ClkSymGen = 1'b0;
    logic             nRst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       targetIdx = 4'h0;
    logic             guessValid = 1'b0;
    logic [CNT_W-1:0] guess = '0;
    logic [3:0]       randomNum;
    logic             symValid;
    logic             busy;
    logic             done;
    logic             correct;
    logic [CNT_W-1:0] targetCount;

    int errors = 0;
    int checks = 0;
    logic [15:0] m_lfsr;

    symbol_round_sequencer #(
        .NUM_SYMS(NUM_SYMS), .CNT_W(CNT_W), .DWELL(DWELL), .GAP(GAP),
        .TMR_W(TMR_W), .SEED(SEED)
    ) dut (
        .ClkSymGen(ClkSymGen), .nRst(nRst), .start(start), .abort(abort),
        .targetIdx(targetIdx), .guessValid(guessValid), .guess(guess),
        .randomNum(randomNum), .symValid(symValid), .busy(busy), .done(done),
        .correct(correct), .targetCount(targetCount)
    );

    always #5 ClkSymGen = ~ClkSymGen;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        lfsr_next = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    task automatic step();
        @(posedge ClkSymGen);
        #1;
    endtask

    // One round: symbols are the next NUM_SYMS LFSR values; each occupies PER cycles.
    task automatic drive_round(input logic [3:0] tgt, input int abort_k, input bit inject,
                               input int hold, input int gdelta, output int cnt_o);
        logic [3:0]       syms [NUM_SYMS];
        int               hits [NUM_SYMS];
        logic [15:0]      l;
        int               cnt;
        int               idx;
        int               loaded;
        logic             exp_v;
        logic             exp_ok;
        logic [CNT_W-1:0] exp_c;
        l = m_lfsr;
        cnt = 0;
        for (int s = 0; s < NUM_SYMS; s++) begin
            syms[s] = l[3:0];
            if (l[3:0] == tgt) cnt++;
            hits[s] = cnt;
            l = lfsr_next(l);
        end
        cnt_o = cnt;
        targetIdx = tgt;
        start = 1'b1;
        step();
        start = 1'b0;
        targetIdx = ~tgt;
        for (int k = 0; k <= ANS_K; k++) begin
            idx   = (k == 0) ? 0 : (k - 1) / PER;
            exp_v = (k >= 1) && (((k - 1) % PER) >= 1) && (((k - 1) % PER) <= DWELL);
            exp_c = (k == 0) ? '0 : CNT_W'(hits[idx]);
            checks++;
            if (symValid !== exp_v) begin
                errors++;
                $display("FAIL symValid k=%0d got=%b exp=%b", k, symValid, exp_v);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_round k=%0d got=%b exp=1", k, busy);
            end
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_round k=%0d got=%b exp=0", k, done);
            end
            checks++;
            if (targetCount !== exp_c) begin
                errors++;
                $display("FAIL targetCount k=%0d got=%0d exp=%0d", k, targetCount, exp_c);
            end
            checks++;
            if (k >= 1) begin
                if (randomNum !== syms[idx]) begin
                    errors++;
                    $display("FAIL randomNum k=%0d got=%h exp=%h", k, randomNum, syms[idx]);
                end
            end else begin
                if (correct !== 1'b0) begin
                    errors++;
                    $display("FAIL correct_cleared got=%b exp=0", correct);
                end
            end
            if (k == abort_k) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                loaded = 0;
                for (int s = 0; s < NUM_SYMS; s++) if (s * PER < k) loaded++;
                checks++;
                if (busy !== 1'b0 || symValid !== 1'b0 || done !== 1'b0 || correct !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_outputs got busy=%b symValid=%b done=%b correct=%b exp=0000",
                             busy, symValid, done, correct);
                end
                checks++;
                if (targetCount !== exp_c) begin
                    errors++;
                    $display("FAIL abort_count got=%0d exp=%0d", targetCount, exp_c);
                end
                for (int s = 0; s < loaded; s++) m_lfsr = lfsr_next(m_lfsr);
                return;
            end
            if (k < ANS_K) begin
                if (inject && k == 2) start = 1'b1;
                if (inject && k == 3) begin
                    guessValid = 1'b1;
                    guess = CNT_W'(cnt);
                end
                step();
                start = 1'b0;
                guessValid = 1'b0;
            end
        end
        for (int h = 0; h < hold; h++) begin
            if (inject && h == 0) start = 1'b1;
            step();
            start = 1'b0;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL answer_wait h=%0d got busy=%b done=%b exp busy=1 done=0", h, busy, done);
            end
        end
        guessValid = 1'b1;
        guess = CNT_W'(cnt + gdelta);
        step();
        guessValid = 1'b0;
        exp_ok = (gdelta == 0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL result_pulse got done=%b busy=%b exp done=1 busy=1", done, busy);
        end
        checks++;
        if (correct !== exp_ok) begin
            errors++;
            $display("FAIL correct got=%b exp=%b", correct, exp_ok);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_result got done=%b busy=%b exp done=0 busy=0", done, busy);
        end
        checks++;
        if (correct !== exp_ok || targetCount !== CNT_W'(cnt)) begin
            errors++;
            $display("FAIL hold_in_idle got correct=%b count=%0d exp correct=%b count=%0d",
                     correct, targetCount, exp_ok, cnt);
        end
        m_lfsr = l;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (randomNum !== 4'h0 || symValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            correct !== 1'b0 || targetCount !== '0) begin
            errors++;
            $display("FAIL reset_state got rn=%h sv=%b busy=%b done=%b corr=%b cnt=%0d exp all 0",
                     randomNum, symValid, busy, done, correct, targetCount);
        end
        #20 nRst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || symValid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_release got busy=%b symValid=%b exp 0 0", busy, symValid);
        end
        m_lfsr = SEED;
    endtask

    task automatic test_count();
        int c;
        drive_round(m_lfsr[3:0], -1, 1'b0, 0, 0, c);
        checks++;
        if (targetCount < CNT_W'(1)) begin
            errors++;
            $display("FAIL count_nonzero got=%0d exp>=1", targetCount);
        end
    endtask

    task automatic test_wrong_guess();
        int c;
        for (int r = 0; r < 2; r++) drive_round(4'($urandom_range(15, 0)), -1, 1'b0, 0, 1, c);
    endtask

    task automatic test_handshake();
        int c;
        drive_round(4'($urandom_range(15, 0)), -1, 1'b1, 100, 0, c);
    endtask

    task automatic test_abort();
        int c;
        drive_round(m_lfsr[3:0], 12, 1'b0, 0, 0, c);
        drive_round(4'($urandom_range(15, 0)), -1, 1'b0, 0, 0, c);
    endtask

    task automatic test_simultaneous();
        int c;
        abort = 1'b1;
        start = 1'b1;
        targetIdx = 4'($urandom_range(15, 0));
        step();
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || symValid !== 1'b0) begin
                errors++;
                $display("FAIL abort_start_idle i=%0d got busy=%b symValid=%b exp 0 0", i, busy, symValid);
            end
            step();
        end
        drive_round(m_lfsr[3:0], -1, 1'b0, 0, 0, c);
    endtask

    task automatic test_reset_mid();
        int c;
        logic [15:0] seed_v;
        targetIdx = 4'h5;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++;
        if (symValid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_show got symValid=%b exp=1", symValid);
        end
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (symValid !== 1'b0 || busy !== 1'b0 || randomNum !== 4'h0 || targetCount !== '0) begin
            errors++;
            $display("FAIL async_reset got sv=%b busy=%b rn=%h cnt=%0d exp 0 0 0 0",
                     symValid, busy, randomNum, targetCount);
        end
        step();
        step();
        #2 nRst = 1'b1;
        seed_v = SEED;
        m_lfsr = seed_v;
        drive_round(seed_v[3:0], -1, 1'b0, 0, 0, c);
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrong_guess();
        test_handshake();
        test_abort();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
